// File: rtl/cflog_pkg.sv
// Shared types and constants for the CFLog monitor (state types, default TCB window, loop tag).
package cflog_pkg;

  typedef enum logic [1:0] {
    PC_NOT_X = 2'd0,
    PC_IN_X  = 2'd1,
    PC_WAIT  = 2'd2
  } pc_st_e;

  typedef enum logic [1:0] {
    LOG_EXEC  = 2'd0,
    LOG_FLUSH = 2'd1,
    LOG_PEND  = 2'd2
  } log_st_e;

  localparam logic [15:0] TCB_MIN_DEF = 16'hA000;
  localparam logic [15:0] TCB_MAX_DEF = 16'hDFFE;

  // Value placed in the entry MSB to mark a loop-count entry.
  localparam logic LOOP_TAG = 1'b1;

endpackage

// File: rtl/cflog_loop_compressor.sv
// Loop-count compression: counts loop edges, then emits a count entry followed by the
// deferred destination entry. Used only when CFLOG_LOOP_CNT_EN is defined.
module cflog_loop_compressor
  import cflog_pkg::*;
#(
  parameter int AW    = 16,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_i,
  input  logic          req_loop_i,
  input  logic          req_force_i,
  input  logic [AW-1:0] req_data_i,
  input  logic          wr_acc_i,
  output logic          cand_vld_o,
  output logic          cand_force_o,
  output logic [AW-1:0] cand_data_o,
  output logic          drop_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             pend_force_q, pend_force_d;
  logic [AW-1:0]    pend_data_q, pend_data_d;
  logic [AW-1:0]    cnt_entry;

  always_comb begin
    cnt_entry            = '0;
    cnt_entry[CNT_W-1:0] = cnt_q;
    cnt_entry[AW-1]      = LOOP_TAG;
  end

  // Output side is kept apart from the next-state side: wr_acc_i depends on cand_*.
  always_comb begin
    cand_vld_o   = 1'b0;
    cand_force_o = 1'b0;
    cand_data_o  = req_data_i;
    drop_o       = 1'b0;
    if (pend_q) begin
      cand_vld_o   = 1'b1;
      cand_force_o = pend_force_q;
      cand_data_o  = pend_data_q;
      drop_o       = req_i;
    end else if (req_i && !req_loop_i) begin
      cand_vld_o   = 1'b1;
      cand_force_o = req_force_i;
      cand_data_o  = (cnt_q != '0) ? cnt_entry : req_data_i;
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    pend_d       = 1'b0;
    pend_force_d = pend_force_q;
    pend_data_d  = pend_data_q;
    if (!pend_q && req_i) begin
      if (req_loop_i) begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else if ((cnt_q != '0) && wr_acc_i) begin
        cnt_d        = '0;
        pend_d       = 1'b1;
        pend_force_d = req_force_i;
        pend_data_d  = req_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_force_q <= 1'b0;
      pend_data_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_force_q <= pend_force_d;
      pend_data_q  <= pend_data_d;
    end
  end

endmodule

// File: rtl/cflog_monitor_gen.sv
// Control-flow log monitor: PC tracker, write gating, pointer and flush handshake.
// Optional loop-count compression is enabled with the CFLOG_LOOP_CNT_EN macro.
//   pc_st    | meaning                         log_st | meaning
//   PC_NOT_X | PC outside the ER               EXEC   | logging normally
//   PC_IN_X  | first cycle inside the ER       FLUSH  | log full, waiting for irq
//   PC_WAIT  | executing inside the ER         PEND   | waiting for flush_ack
module cflog_monitor_gen
  import cflog_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            ENTRY_B  = 2,
  parameter logic [AW-1:0] LOG_SIZE = AW'(16'h0100),
  parameter logic [AW-1:0] TCB_MIN  = AW'(TCB_MIN_DEF),
  parameter logic [AW-1:0] TCB_MAX  = AW'(TCB_MAX_DEF),
  parameter int            CNT_W    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] pc_nxt,
  input  logic [AW-1:0] er_min,
  input  logic [AW-1:0] er_max,
  input  logic          irq,
  input  logic          branch_detect,
  input  logic          loop_detect,
  input  logic [AW-1:0] top_slice,
  input  logic          flush_ack,
  output logic          flush,
  output logic          hw_wr_en,
  output logic [AW-1:0] cflow_log_ptr,
  output logic [AW-1:0] wr_data,
  output logic          log_full,
  output logic          overflow
);

  localparam logic [AW-1:0] STEP     = AW'(ENTRY_B);
  localparam logic [AW-1:0] PTR_LIM  = LOG_SIZE - STEP;
  localparam logic [AW-1:0] PTR_FULL = LOG_SIZE - STEP - STEP;

  pc_st_e        pc_st_q, pc_st_d;
  log_st_e       log_st_q, log_st_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          flush_q, flush_d;
  logic          ovf_q, ovf_d;

  logic pc_in_er, nxt_in_er, pc_in_tcb, nxt_in_tcb;
  logic req_er, req_tcb, req_x, raw_req, ack_kill;
  logic cand_vld, cand_force, cand_adv, src_drop, fits, allowed, wr_acc;
  logic [AW-1:0] cand_data;
  logic [AW:0]   ptr_sum;

  assign pc_in_er   = (pc >= er_min) && (pc <= er_max);
  assign nxt_in_er  = (pc_nxt >= er_min) && (pc_nxt <= er_max);
  assign pc_in_tcb  = (pc >= TCB_MIN) && (pc <= TCB_MAX);
  assign nxt_in_tcb = (pc_nxt >= TCB_MIN) && (pc_nxt <= TCB_MAX);

  assign req_er   = (pc_st_q == PC_NOT_X) && (pc == TCB_MAX) && nxt_in_er && branch_detect;
  assign req_tcb  = !pc_in_tcb && nxt_in_tcb && branch_detect;
  assign req_x    = (pc_st_q != PC_NOT_X) && branch_detect;
  assign raw_req  = req_er || req_tcb || req_x;
  assign ack_kill = (log_st_q == LOG_PEND) && flush_ack;

  // The last slot stays free for the TCB entry, hence the 2*ENTRY_B threshold.
  assign log_full = ((ptr_q + STEP) == top_slice) ||
                    ((top_slice == '0) && (ptr_q == PTR_FULL));

`ifdef CFLOG_LOOP_CNT_EN
  cflog_loop_compressor #(
    .AW    (AW),
    .CNT_W (CNT_W)
  ) u_loop (
    .clk          (clk),
    .reset        (reset),
    .req_i        (raw_req && !ack_kill),
    .req_loop_i   (loop_detect),
    .req_force_i  (req_tcb),
    .req_data_i   (pc_nxt),
    .wr_acc_i     (wr_acc),
    .cand_vld_o   (cand_vld),
    .cand_force_o (cand_force),
    .cand_data_o  (cand_data),
    .drop_o       (src_drop)
  );
  assign cand_adv = 1'b1;
`else
  assign cand_vld   = raw_req;
  assign cand_force = req_tcb;
  assign cand_data  = pc_nxt;
  // A loop edge rewrites the current entry; the header slot at 0 is never rewritten.
  assign cand_adv   = !(loop_detect && (ptr_q != '0));
  assign src_drop   = 1'b0;
`endif

  assign ptr_sum = {1'b0, ptr_q} + {1'b0, STEP};
  assign fits    = !cand_adv || (ptr_sum <= {1'b0, PTR_LIM});
  assign allowed = cand_force || ((log_st_q == LOG_EXEC) && !log_full);
  assign wr_acc  = cand_vld && !ack_kill && allowed && fits;

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q | (cand_vld && !wr_acc) | src_drop | (raw_req && ack_kill);
    if (ack_kill) begin
      ptr_d = '0;
    end else if (wr_acc) begin
      ptr_d     = cand_adv ? ptr_sum[AW-1:0] : ptr_q;
      wr_en_d   = 1'b1;
      wr_data_d = cand_data;
    end
  end

  always_comb begin
    pc_st_d = pc_st_q;
    case (pc_st_q)
      PC_NOT_X: if ((pc != '0) && pc_in_er) pc_st_d = PC_IN_X;
      PC_IN_X:  pc_st_d = pc_in_er ? PC_WAIT : PC_NOT_X;
      PC_WAIT:  if (!pc_in_er) pc_st_d = PC_NOT_X;
      default:  pc_st_d = PC_NOT_X;
    endcase
  end

  always_comb begin
    log_st_d = log_st_q;
    flush_d  = flush_q;
    case (log_st_q)
      LOG_EXEC: begin
        if (log_full) begin
          log_st_d = LOG_FLUSH;
          flush_d  = 1'b1;
        end
      end
      LOG_FLUSH: if (irq) log_st_d = LOG_PEND;
      LOG_PEND: begin
        if (flush_ack) begin
          log_st_d = LOG_EXEC;
          flush_d  = 1'b0;
        end
      end
      default: begin
        log_st_d = LOG_EXEC;
        flush_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_st_q   <= PC_NOT_X;
      log_st_q  <= LOG_EXEC;
      ptr_q     <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      flush_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pc_st_q   <= pc_st_d;
      log_st_q  <= log_st_d;
      ptr_q     <= ptr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      flush_q   <= flush_d;
      ovf_q     <= ovf_d;
    end
  end

  assign flush         = flush_q;
  assign hw_wr_en      = wr_en_q;
  assign cflow_log_ptr = ptr_q;
  assign wr_data       = wr_data_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_cflog_monitor_gen.sv
// Randomised bench for cflog_monitor_gen with a behavioural reference model and directed scenarios.
module tb_cflog_monitor_gen;

  localparam logic [15:0] LOG_SZ = 16'h0010;
  localparam logic [15:0] T_MIN  = 16'hA000;
  localparam logic [15:0] T_MAX  = 16'hDFFE;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc, pc_nxt, er_min, er_max, top_slice;
  logic        irq, branch_detect, loop_detect, flush_ack;
  logic        flush, hw_wr_en, log_full, overflow;
  logic [15:0] cflow_log_ptr, wr_data;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  cflog_monitor_gen #(
    .AW(16), .ENTRY_B(2), .LOG_SIZE(LOG_SZ), .TCB_MIN(T_MIN), .TCB_MAX(T_MAX), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_nxt(pc_nxt), .er_min(er_min), .er_max(er_max),
    .irq(irq), .branch_detect(branch_detect), .loop_detect(loop_detect),
    .top_slice(top_slice), .flush_ack(flush_ack), .flush(flush), .hw_wr_en(hw_wr_en),
    .cflow_log_ptr(cflow_log_ptr), .wr_data(wr_data), .log_full(log_full), .overflow(overflow)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic        m_in_region;   // PC is executing inside the ER (entered with a nonzero PC)
  int          m_phase;       // 0 logging, 1 flush requested, 2 waiting for ack
  logic [15:0] m_ptr, m_data;
  logic        m_wr, m_ovf;
  logic [7:0]  m_cnt;
  logic        m_pend, m_pend_force;
  logic [15:0] m_pend_data;

  function automatic bit in_rng(logic [15:0] a, logic [15:0] lo, logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  function automatic bit full_f(logic [15:0] p, logic [15:0] ts);
    logic [15:0] nxt;
    nxt = p + 16'd2;
    return (nxt == ts) || ((ts == 16'd0) && (p == LOG_SZ - 16'd4));
  endfunction

  always @(posedge clk) begin : model
    bit ra, rb, rc, rq, ack, full, cand, frc, adv, ok, was_pend;
    logic [15:0] cd;
    if (reset) begin
      m_in_region = 0; m_phase = 0; m_ptr = 0; m_data = 0; m_wr = 0; m_ovf = 0;
      m_cnt = 0; m_pend = 0; m_pend_force = 0; m_pend_data = 0;
    end else begin
      full = full_f(m_ptr, top_slice);
      ra  = !m_in_region && (pc == T_MAX) && in_rng(pc_nxt, er_min, er_max) && branch_detect;
      rb  = !in_rng(pc, T_MIN, T_MAX) && in_rng(pc_nxt, T_MIN, T_MAX) && branch_detect;
      rc  = m_in_region && branch_detect;
      rq  = ra || rb || rc;
      ack = (m_phase == 2) && flush_ack;
      m_wr = 0;
      cand = 0; frc = rb; adv = 1; cd = pc_nxt;
      was_pend = m_pend;
`ifdef CFLOG_LOOP_CNT_EN
      if (m_pend) begin
        cand = 1; cd = m_pend_data; frc = m_pend_force;
        if (rq) m_ovf = 1;
      end else if (rq && !ack) begin
        if (loop_detect) begin
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end else begin
          cand = 1;
          if (m_cnt != 0) cd = 16'h8000 | {8'h00, m_cnt};
        end
      end
`else
      cand = rq;
      adv  = !(loop_detect && (m_ptr != 0));
`endif
      ok = cand && !ack && (frc || (m_phase == 0 && !full)) &&
           (!adv || (32'(m_ptr) + 2 <= 32'(LOG_SZ) - 2));
      if ((cand && !ok) || (rq && ack)) m_ovf = 1;
`ifdef CFLOG_LOOP_CNT_EN
      m_pend = 0;
      if (!was_pend && ok && (m_cnt != 0)) begin
        m_pend = 1; m_pend_data = pc_nxt; m_pend_force = rb; m_cnt = 0;
      end
`endif
      if (ack) m_ptr = 0;
      else if (ok) begin
        if (adv) m_ptr = m_ptr + 16'd2;
        m_wr = 1; m_data = cd;
      end
      case (m_phase)
        0: if (full) m_phase = 1;
        1: if (irq) m_phase = 2;
        default: if (flush_ack) m_phase = 0;
      endcase
      m_in_region = in_rng(pc, er_min, er_max) && (m_in_region || pc != 0);
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      check("hw_wr_en", {15'd0, hw_wr_en}, {15'd0, m_wr});
      check("cflow_log_ptr", cflow_log_ptr, m_ptr);
      check("wr_data", wr_data, m_data);
      check("flush", {15'd0, flush}, {15'd0, (m_phase != 0)});
      check("overflow", {15'd0, overflow}, {15'd0, m_ovf});
      check("log_full", {15'd0, log_full}, {15'd0, full_f(m_ptr, top_slice)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    branch_detect = 0; loop_detect = 0; irq = 0; flush_ack = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle(); pc = 16'h0; pc_nxt = 16'h0; top_slice = 16'h0;
    step();
    reset = 0;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hDFFE;
      2, 3: return 16'hE000 + 16'($urandom_range(0, 127) * 2);
      4: return 16'h9000;
      5: return 16'hA000 + 16'($urandom_range(0, 8191) * 2);
      6: return 16'hE100;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    er_min = 16'hE000; er_max = 16'hE0FF;
    do_reset();
    check("reset_ptr", cflow_log_ptr, 16'h0);
    check("reset_wr_en", {15'd0, hw_wr_en}, 16'h0);

    // ER entry from the TCB exit point
    pc = 16'hDFFE; pc_nxt = 16'hE000; branch_detect = 1;
    step();
    check("er_entry_wr_en", {15'd0, hw_wr_en}, 16'h1);
    check("er_entry_ptr", cflow_log_ptr, 16'h0002);
    check("er_entry_data", wr_data, 16'hE000);

    // flush_ack outside PEND has no effect
    idle(); flush_ack = 1;
    step();
    flush_ack = 0;
    check("ack_in_exec_ptr", cflow_log_ptr, 16'h0002);
    check("ack_in_exec_wr", {15'd0, hw_wr_en}, 16'h0);

    // loop handling
    do_reset();
    pc = 16'hE000; step();
    pc = 16'hE004;
`ifdef CFLOG_LOOP_CNT_EN
    pc_nxt = 16'hE000; branch_detect = 1; loop_detect = 1;
    repeat (5) step();
    check("loop_no_strobe", {15'd0, hw_wr_en}, 16'h0);
    loop_detect = 0; pc_nxt = 16'hE040;
    step();
    idle();
    check("cnt_entry_data", wr_data, 16'h8005);
    check("cnt_entry_ptr", cflow_log_ptr, 16'h0002);
    step();
    check("dest_entry_wr", {15'd0, hw_wr_en}, 16'h1);
    check("dest_entry_data", wr_data, 16'hE040);
    check("dest_entry_ptr", cflow_log_ptr, 16'h0004);
`else
    pc_nxt = 16'hE010; branch_detect = 1;
    step();
    check("branch_ptr", cflow_log_ptr, 16'h0002);
    pc_nxt = 16'hE002; loop_detect = 1;
    step();
    idle();
    check("loop_wr", {15'd0, hw_wr_en}, 16'h1);
    check("loop_ptr_held", cflow_log_ptr, 16'h0002);
    check("loop_data", wr_data, 16'hE002);
`endif

    // fill the log
    do_reset();
    pc = 16'hE000; step();
    pc = 16'hE010; pc_nxt = 16'hE020; branch_detect = 1;
    repeat (6) step();
    check("fill_ptr", cflow_log_ptr, 16'h000C);
    check("fill_full", {15'd0, log_full}, 16'h1);
    step();
    check("seventh_no_strobe", {15'd0, hw_wr_en}, 16'h0);
    check("seventh_overflow", {15'd0, overflow}, 16'h1);
    check("flush_raised", {15'd0, flush}, 16'h1);

    // TCB entry uses the reserved slot
    pc = 16'h9000; pc_nxt = 16'hA000;
    step();
    idle();
    check("tcb_wr", {15'd0, hw_wr_en}, 16'h1);
    check("tcb_ptr", cflow_log_ptr, 16'h000E);
    check("tcb_data", wr_data, 16'hA000);

    // flush handshake
    irq = 1; step(); irq = 0;
    flush_ack = 1; step(); flush_ack = 0;
    check("ack_ptr", cflow_log_ptr, 16'h0000);
    check("ack_flush", {15'd0, flush}, 16'h0);

    // reset while flushing
    top_slice = 16'h0002;
    step();
    check("slice_flush", {15'd0, flush}, 16'h1);
    reset = 1; step(); reset = 0;
    check("rst_flush", {15'd0, flush}, 16'h0);
    check("rst_overflow", {15'd0, overflow}, 16'h0);
    check("rst_ptr", cflow_log_ptr, 16'h0000);
    check("rst_data", wr_data, 16'h0000);
    top_slice = 16'h0;

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      pc            = pick_addr();
      pc_nxt        = pick_addr();
      branch_detect = ($urandom_range(0, 1) == 1);
      loop_detect   = ($urandom_range(0, 4) == 0);
      irq           = ($urandom_range(0, 6) == 0);
      flush_ack     = ($urandom_range(0, 3) == 0);
      top_slice     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 9) * 2) : 16'h0;
      step();
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
